// File: rtl/glow_pkg.sv
// Shared types and constants for the LED glow brightness sequencer.
package glow_pkg;

  localparam int unsigned LEVEL_W    = 4;
  localparam int unsigned HOLD_CNT_W = 8;

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'd15;

  typedef enum logic [2:0] {
    StIdle,
    StRampUp,
    StHoldHigh,
    StRampDown,
    StHoldLow
  } glow_state_t;

  // Saturating brightness step: never wraps past 15 or below 0.
  function automatic logic [LEVEL_W-1:0] level_inc(input logic [LEVEL_W-1:0] lvl);
    return (lvl == LEVEL_MAX) ? LEVEL_MAX : lvl + LEVEL_W'(1);
  endfunction

  function automatic logic [LEVEL_W-1:0] level_dec(input logic [LEVEL_W-1:0] lvl);
    return (lvl == '0) ? '0 : lvl - LEVEL_W'(1);
  endfunction

endpackage

// File: rtl/glow_tick.sv
// Step prescaler: counts 0..STEP_DIV-1 while running and flags the last count.
module glow_tick #(
  parameter int unsigned STEP_DIV = 1562500
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic run_i,
  output logic tick_o
);

  localparam int unsigned CntW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STEP_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/glow_sequencer.sv
// Brightness sequencer: ramps a 4-bit level up, holds, ramps down, holds, either
// continuously or as a triggered one-shot. Feeds the 16-level PWM stage.
module glow_sequencer
  import glow_pkg::*;
#(
  parameter int unsigned STEP_DIV        = 1562500,
  parameter int unsigned HOLD_HIGH_STEPS = 8,
  parameter int unsigned HOLD_LOW_STEPS  = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic               oneshot_i,
  input  logic               trigger_i,
  output logic [LEVEL_W-1:0] level_o,
  output logic               busy_o,
  output logic               cycle_done_o
);

  localparam logic [HOLD_CNT_W-1:0] HoldHighLast = HOLD_CNT_W'(HOLD_HIGH_STEPS - 1);
  localparam logic [HOLD_CNT_W-1:0] HoldLowLast  = HOLD_CNT_W'(HOLD_LOW_STEPS - 1);

  glow_state_t             state_q, state_d;
  logic [LEVEL_W-1:0]      level_q, level_d;
  logic [HOLD_CNT_W-1:0]   hold_q, hold_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    tick;
  logic                    in_idle;
  glow_state_t             end_state;

  assign in_idle = (state_q == StIdle);

  // Cleared while idle, so the first step after a start is a full STEP_DIV period.
  glow_tick #(
    .STEP_DIV(STEP_DIV)
  ) u_tick (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(in_idle),
    .run_i  (!in_idle),
    .tick_o (tick)
  );

  // Continuous mode restarts without an idle clock in between.
  assign end_state = (enable_i && !oneshot_i) ? StRampUp : StIdle;

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    hold_d  = hold_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        level_d = '0;
        if (enable_i && (!oneshot_i || trigger_i)) begin
          state_d = StRampUp;
        end
      end
      StRampUp: begin
        if (!enable_i) begin
          state_d = StRampDown;
        end else if (tick) begin
          level_d = level_inc(level_q);
          if (level_q >= LEVEL_MAX - LEVEL_W'(1)) begin
            state_d = (HOLD_HIGH_STEPS == 0) ? StRampDown : StHoldHigh;
          end
        end
      end
      StHoldHigh: begin
        if (!enable_i) begin
          state_d = StRampDown;
        end else if (tick) begin
          hold_d = hold_q + HOLD_CNT_W'(1);
          if (hold_q == HoldHighLast) begin
            state_d = StRampDown;
          end
        end
      end
      StRampDown: begin
        if (tick) begin
          level_d = level_dec(level_q);
          // Level 0 also exits, so an early enable drop cannot stall here.
          if (level_q <= LEVEL_W'(1)) begin
            if (HOLD_LOW_STEPS == 0) begin
              done_d  = 1'b1;
              state_d = end_state;
            end else begin
              state_d = StHoldLow;
            end
          end
        end
      end
      StHoldLow: begin
        if (tick) begin
          hold_d = hold_q + HOLD_CNT_W'(1);
          if (hold_q == HoldLowLast) begin
            done_d  = 1'b1;
            state_d = end_state;
          end
        end
      end
      default: begin
        state_d = StIdle;
        level_d = '0;
      end
    endcase

    if (state_d != state_q || done_d) begin
      hold_d = '0;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      level_q <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign level_o      = level_q;
  assign busy_o       = busy_q;
  assign cycle_done_o = done_q;

endmodule

// File: tb/tb_glow_sequencer.sv
// Directed bench for glow_sequencer: two instances (paced with holds, and
// STEP_DIV=1 with zero holds) driven from one linear stimulus sequence.
module tb_glow_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_reset, a_enable, a_oneshot, a_trigger;
  logic [3:0] a_level;
  logic       a_busy, a_done;

  logic       b_reset, b_enable, b_oneshot, b_trigger;
  logic [3:0] b_level;
  logic       b_busy, b_done;

  glow_sequencer #(
    .STEP_DIV       (4),
    .HOLD_HIGH_STEPS(2),
    .HOLD_LOW_STEPS (2)
  ) u_dut_a (
    .clk_i       (clk),
    .reset_i     (a_reset),
    .enable_i    (a_enable),
    .oneshot_i   (a_oneshot),
    .trigger_i   (a_trigger),
    .level_o     (a_level),
    .busy_o      (a_busy),
    .cycle_done_o(a_done)
  );

  glow_sequencer #(
    .STEP_DIV       (1),
    .HOLD_HIGH_STEPS(0),
    .HOLD_LOW_STEPS (0)
  ) u_dut_b (
    .clk_i       (clk),
    .reset_i     (b_reset),
    .enable_i    (b_enable),
    .oneshot_i   (b_oneshot),
    .trigger_i   (b_trigger),
    .level_o     (b_level),
    .busy_o      (b_busy),
    .cycle_done_o(b_done)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Advance n clocks; outputs are sampled and inputs changed 1 ns after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, exp, $time);
      $error("check %s mismatched", tag);
    end
  endtask

  // Level k clocks into a cycle of instance A: one step per 4 clks, 15 for
  // ticks 15..17, down to 0 by tick 32, then 0 through the low hold.
  function automatic int exp_a_level(input int k);
    int t;
    t = k / 4;
    if (t <= 15) return t;
    if (t <= 17) return 15;
    if (t <= 32) return 32 - t;
    return 0;
  endfunction

  initial begin
    int n0, m0, p0, s0, k, hi15, zeros, ndone, done_at, e;

    a_reset = 1'b1; a_enable = 1'b0; a_oneshot = 1'b0; a_trigger = 1'b0;
    b_reset = 1'b1; b_enable = 1'b0; b_oneshot = 1'b0; b_trigger = 1'b0;
    step(2);
    chk("rst_a_level", a_level, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_b_level", b_level, 0);
    chk("rst_b_busy", b_busy, 0);
    a_reset = 1'b0;
    b_reset = 1'b0;
    step(3);
    chk("idle_disabled_busy", a_busy, 0);

    // Continuous run on A: two full cycles, checked clock by clock.
    a_enable = 1'b1;
    n0 = cyc;
    hi15 = 0;
    ndone = 0;
    for (int r = 1; r <= 272; r++) begin
      step(1);
      k = (r - 1) % 136;
      chk($sformatf("cont_level_r%0d", r), a_level, exp_a_level(k));
      chk($sformatf("cont_done_r%0d", r), a_done, (k == 0 && r > 1));
      chk($sformatf("cont_busy_r%0d", r), a_busy, 1);
      if (a_level == 4'd15) hi15++;
      ndone += int'(a_done);
    end
    chk("cont_level15_clks", hi15, 24);
    chk("cont_done_count", ndone, 1);

    // Drop enable inside HOLD_HIGH of the third cycle (k = 62).
    step(n0 + 335 - cyc);
    chk("drop_pre_level", a_level, 15);
    a_enable = 1'b0;
    step(1);
    chk("drop_next_level", a_level, 15);
    chk("drop_next_busy", a_busy, 1);
    step(1);
    chk("drop_first_down", a_level, 14);
    step(n0 + 393 - cyc);
    chk("drop_reach_zero", a_level, 0);
    chk("drop_zero_busy", a_busy, 1);
    step(n0 + 400 - cyc);
    chk("drop_holdlow_done", a_done, 0);
    chk("drop_holdlow_busy", a_busy, 1);
    step(1);
    chk("drop_end_done", a_done, 1);
    chk("drop_end_busy", a_busy, 0);
    chk("drop_end_level", a_level, 0);
    step(1);
    chk("drop_done_pulse", a_done, 0);
    step(18);
    chk("drop_no_restart", a_busy, 0);

    // One-shot: trigger without enable, enable without trigger, then a real start.
    a_oneshot = 1'b1;
    a_trigger = 1'b1;
    step(1);
    a_trigger = 1'b0;
    step(3);
    chk("trig_no_enable", a_busy, 0);
    a_enable = 1'b1;
    step(3);
    chk("oneshot_wait_trig", a_busy, 0);
    a_trigger = 1'b1;
    m0 = cyc;
    step(1);
    a_trigger = 1'b0;
    chk("oneshot_busy", a_busy, 1);
    ndone = 0;
    done_at = 0;
    for (int r = 2; r <= 220; r++) begin
      step(1);
      if (a_done) begin
        ndone++;
        done_at = r;
      end
      if (r == 136) chk("oneshot_holdlow_busy", a_busy, 1);
      if (r == 137) chk("oneshot_end_busy", a_busy, 0);
      a_trigger = (r == 50);
    end
    chk("oneshot_done_count", ndone, 1);
    chk("oneshot_done_at", done_at, 137);
    chk("oneshot_final_busy", a_busy, 0);
    chk("oneshot_final_level", a_level, 0);

    // Reset in RAMP_UP at level 7, then restart latency with enable held high.
    a_oneshot = 1'b0;
    p0 = cyc;
    step(30);
    chk("rampup_level7", a_level, 7);
    a_reset = 1'b1;
    step(1);
    chk("midrst_level", a_level, 0);
    chk("midrst_busy", a_busy, 0);
    chk("midrst_done", a_done, 0);
    a_reset = 1'b0;
    step(1);
    chk("lat_busy_n1", a_busy, 1);
    chk("lat_level_n1", a_level, 0);
    step(3);
    chk("lat_level_n4", a_level, 0);
    step(1);
    chk("lat_level_n5", a_level, 1);
    e = cyc - p0;
    chk("lat_elapsed", e, 36);
    a_enable = 1'b0;

    // Zero holds, STEP_DIV = 1: 30-clk triangle wave.
    b_enable = 1'b1;
    s0 = cyc;
    hi15 = 0;
    zeros = 0;
    ndone = 0;
    for (int r = 1; r <= 91; r++) begin
      step(1);
      k = (r - 1) % 30;
      chk($sformatf("tri_level_r%0d", r), b_level, (k <= 15) ? k : 30 - k);
      chk($sformatf("tri_done_r%0d", r), b_done, (k == 0 && r > 1));
      if (b_level == 4'd15) hi15++;
      if (b_level == 4'd0) zeros++;
      ndone += int'(b_done);
    end
    chk("tri_level15_clks", hi15, 3);
    chk("tri_level0_clks", zeros, 4);
    chk("tri_done_count", ndone, 3);
    chk("tri_elapsed", cyc - s0, 91);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/glow_sequencer.md
# glow_sequencer

Brightness sequencer for the LED glow demo: generates the 4-bit `level` word consumed by the 16-level `pwmGenerator`. It ramps `level` up from 0 to 15, holds it high, ramps it down to 0 and holds it low, paced by an internal step prescaler. It runs either continuously ("breathing") or as a triggered one-shot, and sits between the board's buttons/config and the PWM stage.

## Interface
- `STEP_DIV`, default 1_562_500: clk cycles per step tick (16 steps/s at 25 MHz); legal range ≥ 1.
- `HOLD_HIGH_STEPS`, default 8: ticks spent at level 15 after the up-ramp; legal range 0..255.
- `HOLD_LOW_STEPS`, default 8: ticks spent at level 0 after the down-ramp; legal range 0..255.

- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  sequencer enable.
- `oneshot`  in  1  1 = triggered single cycle; 0 = continuous.
- `trigger`  in  1  start pulse, oneshot mode only.
- `level`  out  4  brightness word to `pwmGenerator.level`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `cycle_done`  out  1  one-clk pulse at the end of each full glow cycle.

## Operation
- States:
  - IDLE: `level` = 0.
  - RAMP_UP.
  - HOLD_HIGH.
  - RAMP_DOWN.
  - HOLD_LOW.
- Prescaler: counts 0..STEP_DIV-1 and wraps while state ≠ IDLE.
  - `tick` = (count == STEP_DIV-1).
  - The count is forced to 0 in IDLE and on IDLE exit.
  - STEP_DIV = 1 gives a tick every clk.
- Hold counter: 8 bits, cleared on every state change, incremented on each tick in the HOLD states.
- IDLE: start condition = enable && (!oneshot || trigger). When met, the next state is RAMP_UP.
- RAMP_UP: on each tick, `level`+1. On the tick that makes `level` 15:
  - go to HOLD_HIGH, or
  - go to RAMP_DOWN if HOLD_HIGH_STEPS = 0.
- HOLD_HIGH: on the tick where hold_cnt == HOLD_HIGH_STEPS-1, go to RAMP_DOWN.
- RAMP_DOWN: on each tick, `level`-1. On the tick that makes `level` 0:
  - go to HOLD_LOW, or
  - if HOLD_LOW_STEPS = 0, take the end-of-cycle action directly.
- HOLD_LOW: on the tick where hold_cnt == HOLD_LOW_STEPS-1, take the end-of-cycle action.
- End of cycle: `cycle_done` = 1 for one clk, coincident with leaving the state.
  - Next state is RAMP_UP if enable && !oneshot; otherwise IDLE.
- Enable dropped while in RAMP_UP or HOLD_HIGH:
  - Next clk: state becomes RAMP_DOWN, `level` is unchanged, hold counter is cleared, prescaler continues.
  - The cycle then finishes normally to IDLE, and `cycle_done` still pulses.
- Enable dropped while in RAMP_DOWN or HOLD_LOW: no change; the cycle completes, then IDLE.
- `trigger` is ignored when state ≠ IDLE or when enable = 0.
- `oneshot` is sampled only at IDLE exit and at end of cycle.
- `level` never wraps: increments stop at 15 and decrements stop at 0.

## Timing
- All outputs are registered.
- Reset values:
  - `level` = 0, `busy` = 0, `cycle_done` = 0.
  - State IDLE; prescaler and hold counter = 0.
- Reset takes effect at the next clk edge in any state and overrides every other input.
- Start latency: start condition true in clk N gives:
  - `busy` = 1 at N+1;
  - first tick at N+STEP_DIV;
  - `level` = 1 at N+STEP_DIV+1.
- Cycle length in ticks = 30 + HOLD_HIGH_STEPS + HOLD_LOW_STEPS. In continuous mode the `cycle_done` period is that value × STEP_DIV clks.
- Restart in continuous mode is seamless: no IDLE clk and no prescaler reset between cycles.

## Structure
- Package `glow_pkg`:
  - state enum `glow_state_t` (IDLE, RAMP_UP, HOLD_HIGH, RAMP_DOWN, HOLD_LOW);
  - `LEVEL_W` = 4;
  - `LEVEL_MAX` = 4'd15.
- Sub-module `glow_tick`: parameterised prescaler.
  - Inputs: `clk`, `reset`, `clear`, `run`.
  - Output: `tick`.
  - Counter width = $clog2(STEP_DIV) (min 1).
- Top level of the demo wires `level` to `pwmGenerator`. The sequencer does not instantiate the PWM stage.

## Test plan
- Continuous mode (STEP_DIV=4, HOLD_HIGH_STEPS=2, HOLD_LOW_STEPS=2), enable=1, oneshot=0:
  - `level` steps 0→15, one step every 4 clks;
  - holds 15 for 8 clks, steps 15→0, holds 0 for 8 clks;
  - `cycle_done` is a 1-clk pulse every 136 clks with no gap before the restart.
- Triggered one-shot (oneshot=1), trigger pulsed once:
  - exactly one cycle, one `cycle_done`, then `busy` = 0 and `level` = 0;
  - a second trigger mid-cycle has no effect;
  - trigger with enable = 0 leaves the block in IDLE.
- Enable drop during HOLD_HIGH:
  - next clk is RAMP_DOWN with `level` = 15;
  - ramps down to 0, does HOLD_LOW, pulses `cycle_done` and ends in IDLE;
  - it does not restart.
- Zero holds (STEP_DIV=1, both hold counts 0), continuous:
  - triangle wave 0,1..15,14..1,0 with a 30-clk period;
  - 15 and 0 each last exactly 1 clk; `cycle_done` on every 30th clk.
- Reset asserted in RAMP_UP at `level` 7:
  - next clk: `level` 0, `busy` 0, `cycle_done` 0;
  - with enable still 1 after reset releases, the start latency is as specified.
- Start latency check (STEP_DIV=4): start condition true at clk 10 gives `busy` at clk 11 and `level` = 1 at clk 15.
